dram_arbiter_4: RTL and testbench

DRAM_ARBITER_4 -- requirements
Module: dram_arbiter_4

---
 rtl/dram_arb_pkg.sv | 23 ++
 rtl/rr_sel_4.sv | 29 ++
 rtl/dram_arbiter_4.sv | 126 ++++++++++++
 tb/tb_dram_arbiter_4.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types for the 4-core DRAM arbiter: FSM states, requester ids and
// the external-loader id.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    // Cores are ids 0-3; the external loader is id 4.
    typedef logic [2:0] req_id_t;

    localparam req_id_t    EXT_ID        = 3'd4;
    localparam logic [1:0] LAST_CORE_RST = 2'd3;

    // One-hot core vector for a requester id; the external id maps to no core.
    function automatic logic [3:0] core_onehot(input req_id_t id);
        core_onehot = id[2] ? 4'b0000 : (4'b0001 << id[1:0]);
    endfunction

endpackage

// File: rtl/rr_sel_4.sv
// Combinational 4-way round-robin selector: the search starts just after
// `last`, and the first active request in that order wins.
module rr_sel_4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [3:0] gnt,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        gnt  = 4'b0000;
        idx  = 2'd0;
        cand = 2'd0;
        // Walk from lowest to highest priority; the nearest requester after
        // `last` is visited last and overwrites any earlier candidate.
        for (int off = 4; off >= 1; off--) begin
            cand = last + 2'(off);
            if (req[cand]) begin
                gnt = 4'b0001 << cand;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter_4.sv
// Four-core round-robin DRAM arbiter with one access in flight at a time.
// Define ARB_EXT_PORT_EN to add an external loader port with fixed top priority.
module dram_arbiter_4
    import dram_arb_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 9,
    parameter int NUM_CORES = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           rdata,
`ifdef ARB_EXT_PORT_EN
    input  logic                        ext_req,
    input  logic                        ext_we,
    input  logic [ADDR_W-1:0]           ext_addr,
    input  logic [DATA_W-1:0]           ext_wdata,
    output logic                        ext_gnt,
    output logic                        ext_rvalid,
`endif
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_we,
    output logic                        mem_re,
    input  logic [DATA_W-1:0]           mem_rdata
);

    arb_state_t        state, state_nxt;
    req_id_t           win_id, sel_id;
    logic              win_we, sel_we;
    logic [ADDR_W-1:0] win_addr, sel_addr;
    logic [DATA_W-1:0] win_wdata, sel_wdata;
    logic [1:0]        last_core;
    logic [3:0]        rr_gnt;
    logic [1:0]        rr_idx;
    logic              ext_pend;
    logic              take;

    rr_sel_4 u_rr_sel (
        .req  (core_req),
        .last (last_core),
        .gnt  (rr_gnt),
        .idx  (rr_idx)
    );

`ifdef ARB_EXT_PORT_EN
    assign ext_pend = ext_req;
`else
    assign ext_pend = 1'b0;
`endif

    // Winner candidate: the round-robin core, overridden by the external loader.
    always_comb begin
        sel_id    = {1'b0, rr_idx};
        sel_we    = core_we[rr_idx];
        sel_addr  = core_addr[int'(rr_idx)*ADDR_W +: ADDR_W];
        sel_wdata = core_wdata[int'(rr_idx)*DATA_W +: DATA_W];
`ifdef ARB_EXT_PORT_EN
        if (ext_req) begin
            sel_id    = EXT_ID;
            sel_we    = ext_we;
            sel_addr  = ext_addr;
            sel_wdata = ext_wdata;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ext_pend || (|rr_gnt)) state_nxt = ISSUE;
            ISSUE:   state_nxt = win_we ? IDLE : WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign take = (state == IDLE) && (state_nxt == ISSUE);

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            last_core <= LAST_CORE_RST;
            win_id    <= '0;
            win_we    <= 1'b0;
            win_addr  <= '0;
            win_wdata <= '0;
            rdata     <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                win_id    <= sel_id;
                win_we    <= sel_we;
                win_addr  <= sel_addr;
                win_wdata <= sel_wdata;
                // The external loader never moves the core rotation.
                if (!sel_id[2]) last_core <= rr_idx;
            end
            if (state == WAIT) rdata <= mem_rdata;
        end
    end

    // The winner registers only change on a new arbitration, so the command
    // bus naturally holds its last values outside ISSUE.
    assign mem_addr    = win_addr;
    assign mem_wdata   = win_wdata;
    assign mem_we      = (state == ISSUE) && win_we;
    assign mem_re      = (state == ISSUE) && !win_we;
    assign core_gnt    = (state == ISSUE) ? core_onehot(win_id) : '0;
    assign core_rvalid = (state == RESP)  ? core_onehot(win_id) : '0;

`ifdef ARB_EXT_PORT_EN
    assign ext_gnt    = (state == ISSUE) && (win_id == EXT_ID);
    assign ext_rvalid = (state == RESP)  && (win_id == EXT_ID);
`endif

endmodule

// File: tb/tb_dram_arbiter_4.sv
// Directed and randomised bench for dram_arbiter_4 against a transaction-level
// model. Define ARB_EXT_PORT_EN to also exercise the external loader port.
`timescale 1ns/1ps
module tb_dram_arbiter_4;

    localparam int DW = 16;
    localparam int AW = 9;

    logic            clock = 1'b0;
    logic            reset;
    logic [3:0]      core_req, core_we;
    logic [4*AW-1:0] core_addr;
    logic [4*DW-1:0] core_wdata;
    logic [3:0]      core_gnt, core_rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic            mem_we, mem_re;
`ifdef ARB_EXT_PORT_EN
    logic            ext_req, ext_we, ext_gnt, ext_rvalid;
    logic [AW-1:0]   ext_addr;
    logic [DW-1:0]   ext_wdata;
`endif

    dram_arbiter_4 #(.DATA_W(DW), .ADDR_W(AW), .NUM_CORES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .rdata       (rdata),
`ifdef ARB_EXT_PORT_EN
        .ext_req     (ext_req),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_gnt     (ext_gnt),
        .ext_rvalid  (ext_rvalid),
`endif
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'((i * 40503) ^ 32'h5A5A);
    endfunction

    // DRAM: read data appears exactly one cycle after mem_re, X otherwise.
    logic [DW-1:0] dram [512];
    initial begin
        for (int i = 0; i < 512; i++) dram[i] = init_val(i);
        dram[5] = 16'h00AB;
        forever begin
            @(posedge clock);
            if (mem_we) dram[mem_addr] = mem_wdata;
            mem_rdata <= mem_re ? dram[mem_addr] : 'x;
        end
    end

    // Reference model state: timing follows the latency rules directly.
    logic [DW-1:0] ref_mem [512];
    int            cyc, next_arb, exp_gnt_cyc, exp_rv_cyc, rst_cyc, exp_id, m_last;
    logic          op_we;
    logic [AW-1:0] op_addr, m_addr;
    logic [DW-1:0] op_wdata, pend_rdata, m_wdata, m_rdata;
    int            n_vec, n_err;
    bit            continuous, rand_en;
    int            gnt_log[$];
    int            gnt_cyc_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Decide what the arbiter does with the inputs present in cycle `cyc`.
    task automatic model_step();
        int w;
        w = -1;
        if (reset) begin
            next_arb    = cyc + 1;
            exp_gnt_cyc = -1;
            exp_rv_cyc  = -1;
            rst_cyc     = cyc + 1;
            m_last      = 3;
        end else if (cyc == next_arb) begin
`ifdef ARB_EXT_PORT_EN
            if (ext_req) w = 4;
`endif
            for (int k = 1; k <= 4; k++)
                if (w < 0 && core_req[(m_last + k) % 4]) w = (m_last + k) % 4;
            if (w < 0) begin
                next_arb = cyc + 1;
            end else begin
                exp_id      = w;
                exp_gnt_cyc = cyc + 1;
`ifdef ARB_EXT_PORT_EN
                if (w == 4) begin
                    op_we    = ext_we;
                    op_addr  = ext_addr;
                    op_wdata = ext_wdata;
                end
`endif
                if (w < 4) begin
                    op_we    = core_we[w];
                    op_addr  = core_addr[w*AW +: AW];
                    op_wdata = core_wdata[w*DW +: DW];
                    m_last   = w;
                end
                if (op_we) begin
                    ref_mem[op_addr] = op_wdata;
                    next_arb = cyc + 2;
                end else begin
                    pend_rdata = ref_mem[op_addr];
                    exp_rv_cyc = cyc + 3;
                    next_arb   = cyc + 4;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic       issue;
        logic [3:0] e_gnt, e_rv;
        if (cyc == rst_cyc) begin
            m_addr  = '0;
            m_wdata = '0;
            m_rdata = '0;
        end
        issue = (cyc == exp_gnt_cyc);
        if (issue) begin
            m_addr  = op_addr;
            m_wdata = op_wdata;
        end
        if (cyc == exp_rv_cyc) m_rdata = pend_rdata;
        e_gnt = (issue && exp_id < 4) ? 4'(1 << exp_id) : 4'b0000;
        e_rv  = (cyc == exp_rv_cyc && exp_id < 4) ? 4'(1 << exp_id) : 4'b0000;
        check("core_gnt", core_gnt, e_gnt);
        check("core_rvalid", core_rvalid, e_rv);
        check("mem_we", mem_we, issue && op_we);
        check("mem_re", mem_re, issue && !op_we);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("rdata", rdata, m_rdata);
`ifdef ARB_EXT_PORT_EN
        check("ext_gnt", ext_gnt, issue && exp_id == 4);
        check("ext_rvalid", ext_rvalid, cyc == exp_rv_cyc && exp_id == 4);
`endif
        for (int i = 0; i < 4; i++)
            if (core_gnt[i]) begin
                gnt_log.push_back(i);
                gnt_cyc_log.push_back(cyc);
            end
    endtask

    task automatic rand_reqs();
        for (int i = 0; i < 4; i++) begin
            if (!core_req[i]) begin
                if ($urandom_range(0, 2) == 0) begin
                    core_req[i]            = 1'b1;
                    core_we[i]             = 1'($urandom_range(0, 1));
                    core_addr[i*AW +: AW]  = ($urandom_range(0, 9) == 0) ? 9'd511 : 9'($urandom_range(0, 7));
                    core_wdata[i*DW +: DW] = 16'($urandom);
                end
            end else if ($urandom_range(0, 19) == 0) begin
                core_req[i] = 1'b0;
            end
        end
`ifdef ARB_EXT_PORT_EN
        if (!ext_req && $urandom_range(0, 7) == 0) begin
            ext_req   = 1'b1;
            ext_we    = 1'($urandom_range(0, 1));
            ext_addr  = 9'($urandom_range(0, 7));
            ext_wdata = 16'($urandom);
        end
`endif
        reset = ($urandom_range(0, 149) == 0);
    endtask

    // Requesters drop their request once they see their grant.
    task automatic drive_next();
        for (int i = 0; i < 4; i++)
            if (core_gnt[i] && !continuous) core_req[i] = 1'b0;
`ifdef ARB_EXT_PORT_EN
        if (ext_gnt) ext_req = 1'b0;
`endif
        if (rand_en) rand_reqs();
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        cyc++;
        check_outputs();
        drive_next();
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        continuous = 1'b0; rand_en = 1'b0;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
        ref_mem[5] = 16'h00AB;
        reset = 1'b1;
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
`ifdef ARB_EXT_PORT_EN
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
`endif
        m_last = 3; next_arb = 0; exp_gnt_cyc = -1; exp_rv_cyc = -1; rst_cyc = -1; exp_id = 0;
        op_we = 1'b0; op_addr = '0; op_wdata = '0; pend_rdata = '0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check_outputs();
        cycle();
        reset = 1'b0;

        // Single read by core 2 of DRAM[5].
        core_req[2] = 1'b1; core_we[2] = 1'b0;
        core_addr[2*AW +: AW] = 9'd5; core_wdata[2*DW +: DW] = 16'h1234;
        cycle();
        check("t_read_gnt", core_gnt, 4'b0100);
        cycle();
        cycle();
        check("t_read_rvalid", core_rvalid, 4'b0100);
        check("t_read_rdata", rdata, 16'h00AB);
        cycle();

        // Reset while a core 1 read sits in WAIT.
        core_req[1] = 1'b1; core_we[1] = 1'b0; core_addr[1*AW +: AW] = 9'd7;
        cycle();
        check("t_abort_gnt", core_gnt, 4'b0010);
        cycle();
        reset = 1'b1;
        cycle();
        check("t_abort_no_rvalid", core_rvalid, 4'b0000);
        reset = 1'b0;
        core_req[0] = 1'b1; core_we[0] = 1'b0; core_addr[0*AW +: AW] = 9'd5;
        core_req[1] = 1'b1;
        cycle();
        check("t_abort_core0_first", core_gnt, 4'b0001);
        repeat (12) cycle();

        // All four cores write back-to-back after reset.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            core_addr[i*AW +: AW]  = 9'(100 + i);
            core_wdata[i*DW +: DW] = 16'($urandom);
        end
        core_we = 4'hF; core_req = 4'hF; continuous = 1'b1;
        gnt_log.delete(); gnt_cyc_log.delete();
        repeat (10) cycle();
        continuous = 1'b0; core_req = '0;
        check("t_rr_count", gnt_log.size(), 5);
        for (int k = 0; k < gnt_log.size(); k++) begin
            check("t_rr_order", gnt_log[k], k % 4);
            if (k > 0) check("t_rr_spacing", gnt_cyc_log[k] - gnt_cyc_log[k-1], 2);
        end

        // Core 3 writes 511, then core 0 reads it back ahead of core 1.
        core_req[3] = 1'b1; core_we[3] = 1'b1;
        core_addr[3*AW +: AW] = 9'd511; core_wdata[3*DW +: DW] = 16'hFFFF;
        cycle();
        check("t_wrap_gnt3", core_gnt, 4'b1000);
        core_req[0] = 1'b1; core_we[0] = 1'b0; core_addr[0*AW +: AW] = 9'd511;
        core_req[1] = 1'b1; core_we[1] = 1'b1;
        core_addr[1*AW +: AW] = 9'd511; core_wdata[1*DW +: DW] = 16'h1111;
        cycle();
        cycle();
        check("t_wrap_gnt0", core_gnt, 4'b0001);
        cycle();
        cycle();
        check("t_wrap_rvalid", core_rvalid, 4'b0001);
        check("t_wrap_rdata", rdata, 16'hFFFF);
        repeat (8) cycle();

`ifdef ARB_EXT_PORT_EN
        // External loader and core 1 together.
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 9'd5;
        core_req[1] = 1'b1; core_we[1] = 1'b1; core_addr[1*AW +: AW] = 9'd20;
        cycle();
        check("t_ext_gnt", ext_gnt, 1'b1);
        check("t_ext_core_idle", core_gnt, 4'b0000);
        repeat (3) cycle();
        cycle();
        check("t_ext_then_core1", core_gnt, 4'b0010);
        repeat (4) cycle();
`endif

        // Random traffic with occasional resets.
        rand_en = 1'b1;
        repeat (800) cycle();
        rand_en = 1'b0;
        reset = 1'b0;
        core_req = '0;
`ifdef ARB_EXT_PORT_EN
        ext_req = 1'b0;
`endif
        repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
